dmem_responder: RTL

- Memory-side responder for the CPU data-memory request interface: accepts one word read/write request, models a fixed multi-cycle access latency, then returns a one-cycle acknowledge with read data.
- Sits between the CPU pipeline's MEM stage (initiator) and the word-organised data storage array.
- Replaces the zero-latency data memory so that CPU stall logic can be exercised.

---
 rtl/cpu_mem_pkg.sv | 14 +
 rtl/dmem_responder_if.sv | 29 ++
 rtl/dmem_responder_array.sv | 48 ++++
 rtl/dmem_responder.sv | 120 ++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared constants and FSM encoding for the CPU data-memory request path.
// The responder, its storage array and any future cache model all import this package.
package cpu_mem_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-memory request bus between the MEM stage (master) and the responder (slave).
interface dmem_responder_if;
    import cpu_mem_pkg::*;

    // Handshake: the master raises req_i with we_i/addr_i/data_i and holds it until it
    // sees the single-cycle ack_o. The slave samples the request only while idle
    // (busy_o=0). data_o and err_o are meaningful in the ack cycle, and data_o holds
    // afterwards. A request still high in the first idle cycle after ack_o is accepted
    // as a new access.
    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [WORD_W-1:0] data_i;
    logic              ack_o;
    logic [WORD_W-1:0] data_o;
    logic              busy_o;
    logic              err_o;

    modport master (
        output req_i, we_i, addr_i, data_i,
        input  ack_o, data_o, busy_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, data_i,
        output ack_o, data_o, busy_o, err_o
    );

endinterface

// File: rtl/dmem_responder_array.sv
// Word storage with a synchronous write and a registered, enable-gated read port.
// The storage itself is never cleared. Only the read register is reset.
module dmem_array
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic              clr_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // clr_i forces zero so that a rejected access reads back as 0 until the next read.
    always_comb begin
        rdata_d = rdata_q;
        if (clr_i) begin
            rdata_d = '0;
        end else if (re_i) begin
            rdata_d = mem_q[idx_i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder. It accepts one word request, counts LATENCY
// edges and then pulses ack_o together with read data or an error flag.
module dmem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 10
) (
    input  logic            clk_i,
    input  logic            rst_i,
    dmem_responder_if.slave bus,
    output state_e          dbg_state_o
);

    localparam int               IDX_W    = $clog2(DEPTH_WORDS);
    localparam int               CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;

    logic              enter_ack;
    logic              acc_we;
    logic              acc_err;
    logic [ADDR_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;

    always_comb begin
        // With LATENCY=1 the access completes on the accept edge, so it must see the live inputs.
        acc_we    = (state_q == IDLE) ? bus.we_i   : we_q;
        acc_addr  = (state_q == IDLE) ? bus.addr_i : addr_q;
        acc_wdata = (state_q == IDLE) ? bus.data_i : wdata_q;
        acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[ADDR_W-1:IDX_W+2] != '0);

        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        enter_ack = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    we_d    = bus.we_i;
                    addr_d  = bus.addr_i;
                    wdata_d = bus.data_i;
                    cnt_d   = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d   = ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = ACK;
                    enter_ack = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ack_d = enter_ack;
        err_d = enter_ack && acc_err;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (enter_ack && acc_we && !acc_err),
        .re_i   (enter_ack && !acc_we && !acc_err),
        .clr_i  (err_d),
        .idx_i  (acc_addr[IDX_W+1:2]),
        .wdata_i(acc_wdata),
        .rdata_o(bus.data_o)
    );

    assign bus.ack_o   = ack_q;
    assign bus.err_o   = err_q;
    assign bus.busy_o  = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule
